axi_sim_mem_slave_128bit: RTL and testbench
===========================================

Name: axi_sim_mem_slave_128bit

Overview:
- AXI4 responder (slave) modelling the DDR controller's AXI port 0 for simulation-only and bring-up builds.
- Lets the 128-bit write/read traffic generators run against an on-chip dual-port array instead of the DDR3 core.
- Supports INCR bursts with one write and one read burst outstanding; the write and read paths are independent.
- Models controller init latency through an init-done output.

Parameters:
- AXI_AW, 32: AXI address width (byte address).
- AXI_DW, 128: data width; fixed at 128, strobe width AXI_DW/8.
- ID_W, 8: AXI ID width.
- MEM_AW, 10: word-address width of the array (2^MEM_AW words of 128 bits).
- INIT_CYCLES, 64: cycles after reset release before ddrc_init_done asserts; must be at least 1.

Ports:
- clk  in  1  AXI clock
- rst_n  in  1  asynchronous active-low reset
- ddrc_init_done  out  1  high once init counter expires; sticky until reset
- awid/awaddr/awlen/awsize/awburst  in  ID_W/AXI_AW/8/3/2  write address channel
- awvalid  in  1;  awready  out  1
- wdata/wstrb/wlast/wvalid  in  AXI_DW/AXI_DW/8/1/1  write data channel;  wready  out  1
- bid/bresp  out  ID_W/2;  bvalid  out  1;  bready  in  1
- arid/araddr/arlen/arsize/arburst  in  ID_W/AXI_AW/8/3/2  read address channel
- arvalid  in  1;  arready  out  1
- rid/rdata/rresp/rlast  out  ID_W/AXI_DW/2/1;  rvalid  out  1;  rready  in  1

Behaviour:
- Reset: all outputs 0; both FSMs to IDLE; init counter 0. The array is not cleared. Reset mid-burst abandons the burst with no response.
- Init: the counter increments each cycle until it reaches INIT_CYCLES, then ddrc_init_done goes to 1. awready and arready are forced to 0 until then.
- Addressing:
  - word index = addr[MEM_AW+3:4]; upper bits alias, lower 4 bits are ignored.
  - The index increments by 1 per beat and wraps modulo 2^MEM_AW.
  - burst/size/lock/qos/urgent/poison are ignored; every burst is treated as INCR of 16-byte beats.
- Write FSM states are W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On the AW handshake, latch id, index and len, clear the beat count, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb at the current index and increments index and count.
  - Final beat is count==len. If wlast=0 on the final beat, set the error flag.
  - If wlast=1 before the final beat, set the error flag and end the burst on that beat.
  - On the ending beat go to W_RESP; bvalid=1 on the next cycle.
  - W_RESP: hold bid and bresp (SLVERR 2'b10 if the error flag is set, else OKAY 2'b00) until bready, then return to W_IDLE.
- Read FSM states are R_IDLE, R_BURST.
  - R_IDLE: arready=1. On the AR handshake, latch id, index and len, and go to R_BURST.
  - R_BURST: the output register loads when (!rvalid || rready) and beats remain. It loads rdata=mem[index], rid, rresp=OKAY, rvalid=1, and rlast=(beat==len).
  - When the rlast beat is accepted with no new load, drop rvalid and return to R_IDLE.
- Timing:
  - First rvalid appears 2 cycles after the AR handshake.
  - With rready held high, beats are back-to-back and a len=N burst completes in N+1 consecutive rvalid cycles.
  - While rvalid=1 and rready=0, rdata/rid/rlast are held stable.
- Simultaneous read and write to the same index in the same cycle: the read returns the old data.
- AW and AR may be accepted in the same cycle; the two channels never stall each other.

Decomposition:
- Shared package: AXI response encodings OKAY=2'b00 and SLVERR=2'b10, plus the W_/R_ state encodings.
- One natural sub-module, sim_mem_dp_128: 1 write port with byte enables, 1 registered read port, read-before-write.

Test Plan:
- Init gating: after rst_n rises, awready and arready stay 0 for INIT_CYCLES=64 cycles. ddrc_init_done and awready rise on cycle 64.
- Single write then read:
  - Write: awaddr=0x40, awlen=0, wdata=0x0123..CDEF with wstrb all ones -> bvalid one cycle after the W beat, bresp=0, bid matches awid.
  - Read: araddr=0x40 -> rvalid 2 cycles after the AR handshake, with the same data, rlast=1.
- Burst with backpressure:
  - Write awlen=7 with incrementing data, then read arlen=7 while toggling rready 1/0.
  - Required: 8 beats in order, data stable during stall cycles, rlast only on beat 8.
- Strobe and wrap:
  - Write wstrb=16'h00FF at index 2^MEM_AW-1 with awlen=1.
  - Required: only the low 8 bytes change at the last index, and the second beat lands at index 0.
- wlast protocol errors:
  - wlast=1 on beat 2 of an awlen=3 burst -> bresp=SLVERR after beat 2.
  - wlast=0 on the final beat -> bresp=SLVERR.
- Concurrent traffic and reset:
  - AW and AR in the same cycle to the same index -> read returns the pre-write data.
  - Assert rst_n low mid read-burst -> rvalid/bvalid drop to 0 immediately, and ddrc_init_done restarts the INIT_CYCLES countdown.

Source files
------------

// File: rtl/axi_sim_mem_slave_128bit_pkg.sv
// Shared encodings for the simulation AXI memory responder: response codes and
// the write/read channel state machines.
package axi_sim_mem_slave_128bit_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BEAT_BYTES = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_sim_mem_slave_128bit_if.sv
// AXI4 bus bundle between a traffic generator (master) and the simulation
// memory responder (slave).
interface axi_sim_mem_slave_128bit_if #(
  parameter int AXI_AW = 32,
  parameter int AXI_DW = 128,
  parameter int ID_W   = 8
);
  logic [ID_W-1:0]     awid;
  logic [AXI_AW-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [AXI_DW-1:0]   wdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [AXI_AW-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [AXI_DW-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_sim_mem_slave_128bit_mem.sv
// 128-bit dual-port array: byte-enabled write port plus a registered read
// port that returns the pre-write contents on a same-address collision.
module sim_mem_dp_128 #(
  parameter int MEM_AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [127:0]      wdata_i,
  input  logic [15:0]       wstrb_i,
  input  logic              re_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [127:0]      rdata_o
);

  logic [127:0] mem_q [2**MEM_AW];
  logic [127:0] rdata_q;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 16; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sim_mem_slave_128bit.sv
// AXI4 INCR-only responder standing in for the DDR controller port during
// bring-up; independent write and read engines over a dual-port array.
//
// state   | meaning
// W_IDLE  | awready high once init is done, waiting for AW
// W_DATA  | wready high, writing one beat per W handshake
// W_RESP  | bvalid high with bid/bresp until bready
// R_IDLE  | arready high once init is done, waiting for AR
// R_BURST | streaming beats through the registered read port
module axi_sim_mem_slave_128bit
  import axi_sim_mem_slave_128bit_pkg::*;
#(
  parameter int AXI_AW      = 32,
  parameter int AXI_DW      = 128,
  parameter int ID_W        = 8,
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic ddrc_init_done_o,
  axi_sim_mem_slave_128bit_if.slave axi
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [MEM_AW-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic              w_final, aw_ready, w_ready, mem_we;

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [8:0]        r_cnt_q, r_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              rlast_q, rlast_d;
  logic              ar_ready, r_load;
  logic [127:0]      mem_rdata;

  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_d == CNT_W'(INIT_CYCLES)) init_done_d = 1'b1;
    end
  end

  assign w_final = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready = init_done_q;
        if (axi.awvalid && init_done_q) begin
          w_id_d    = axi.awid;
          w_idx_d   = axi.awaddr[MEM_AW+3:4];
          w_len_d   = axi.awlen;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi.wvalid) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          w_cnt_d = w_cnt_q + 1'b1;
          // Early wlast ends the burst; a missing wlast on the final beat does not extend it.
          if (w_final != axi.wlast) w_err_d = 1'b1;
          if (w_final || axi.wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign r_load = (!rvalid_q || axi.rready) && (r_cnt_q <= {1'b0, r_len_q});

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;
    ar_ready  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = init_done_q;
        if (axi.arvalid && init_done_q) begin
          r_id_d    = axi.arid;
          r_idx_d   = axi.araddr[MEM_AW+3:4];
          r_len_d   = axi.arlen;
          r_cnt_d   = '0;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (r_load) begin
          rvalid_d = 1'b1;
          rid_d    = r_id_q;
          rlast_d  = (r_cnt_q == {1'b0, r_len_q});
          r_idx_d  = r_idx_q + 1'b1;
          r_cnt_d  = r_cnt_q + 1'b1;
        end else if (rvalid_q && axi.rready) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_err_q     <= 1'b0;
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_idx_q     <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rlast_q     <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_err_q     <= w_err_d;
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_idx_q     <= r_idx_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rlast_q     <= rlast_d;
    end
  end

  sim_mem_dp_128 #(.MEM_AW(MEM_AW)) u_mem (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (mem_we),
    .waddr_i (w_idx_q),
    .wdata_i (axi.wdata),
    .wstrb_i (axi.wstrb),
    .re_i    (r_load && r_state_q == R_BURST),
    .raddr_i (r_idx_q),
    .rdata_o (mem_rdata)
  );

  assign ddrc_init_done_o = init_done_q;
  assign axi.awready      = aw_ready;
  assign axi.wready       = w_ready;
  assign axi.bvalid       = (w_state_q == W_RESP);
  assign axi.bid          = w_id_q;
  assign axi.bresp        = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.arready      = ar_ready;
  assign axi.rvalid       = rvalid_q;
  assign axi.rid          = rid_q;
  assign axi.rdata        = mem_rdata[AXI_DW-1:0];
  assign axi.rresp        = RESP_OKAY;
  assign axi.rlast        = rlast_q;

  // Size, burst type and the untranslated address bits are accepted but have no effect.
  logic unused_ok;
  assign unused_ok = ^{axi.awsize, axi.awburst, axi.arsize, axi.arburst,
                       axi.awaddr[AXI_AW-1:MEM_AW+4], axi.awaddr[3:0],
                       axi.araddr[AXI_AW-1:MEM_AW+4], axi.araddr[3:0],
                       init_cnt_q};

endmodule

// File: tb/tb_axi_sim_mem_slave_128bit.sv
// Randomized bench for the simulation AXI memory responder, checked against a
// word-array memory model and per-burst response expectations.
module tb_axi_sim_mem_slave_128bit;
  localparam int AXI_AW = 32, AXI_DW = 128, ID_W = 8, MEM_AW = 10, INIT_CYCLES = 64;
  localparam int DEPTH = 1 << MEM_AW;

  logic clk, rst_n, init_done;
  int checks = 0, errors = 0;
  logic [127:0] mdl  [DEPTH];
  logic [127:0] wbuf [256];

  axi_sim_mem_slave_128bit_if #(.AXI_AW(AXI_AW), .AXI_DW(AXI_DW), .ID_W(ID_W)) axi ();

  axi_sim_mem_slave_128bit #(
    .AXI_AW(AXI_AW), .AXI_DW(AXI_DW), .ID_W(ID_W), .MEM_AW(MEM_AW), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ddrc_init_done_o (init_done),
    .axi              (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd4; axi.awburst = 2'b01;
    axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd4; axi.arburst = 2'b01;
    axi.arvalid = 1'b0;
    axi.rready = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old_w, input logic [127:0] new_w,
                                         input logic [15:0] strb);
    logic [127:0] r;
    r = old_w;
    for (int b = 0; b < 16; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // last_beat: beat index carrying wlast (-1: never asserted)
  task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input int last_beat, input logic [15:0] strb, input bit gaps);
    int nbeats, guard, idx;
    logic [1:0] exp_resp;
    exp_resp = (last_beat != len) ? 2'b10 : 2'b00;
    nbeats   = (last_beat >= 0 && last_beat < len) ? last_beat + 1 : len + 1;
    idx      = int'(addr[MEM_AW+3:4]);
    axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len); axi.awvalid = 1'b1;
    guard = 0;
    while (axi.awready !== 1'b1 && guard < 200) begin tick(); guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL aw_timeout awready=%b required 1", axi.awready);
    end
    tick();
    axi.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      axi.wvalid = 1'b1; axi.wdata = wbuf[b]; axi.wstrb = strb; axi.wlast = (b == last_beat);
      guard = 0;
      while (axi.wready !== 1'b1 && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin
        checks++; errors++;
        $display("FAIL w_timeout wready=%b required 1", axi.wready);
      end
      tick();
      mdl[(idx + b) % DEPTH] = merge(mdl[(idx + b) % DEPTH], wbuf[b], strb);
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
    end
    checks++;
    if (axi.bvalid !== 1'b1) begin
      errors++; $display("FAIL b_latency bvalid=%b required 1", axi.bvalid);
    end
    checks++;
    if (axi.bresp !== exp_resp) begin
      errors++; $display("FAIL b_resp bresp=%b required %b", axi.bresp, exp_resp);
    end
    checks++;
    if (axi.bid !== id) begin
      errors++; $display("FAIL b_id bid=%h required %h", axi.bid, id);
    end
    repeat ($urandom_range(0, 2)) begin
      tick();
      checks++;
      if ({axi.bvalid, axi.bresp, axi.bid} !== {1'b1, exp_resp, id}) begin
        errors++;
        $display("FAIL b_hold got %b/%b/%h required 1/%b/%h", axi.bvalid, axi.bresp, axi.bid,
                 exp_resp, id);
      end
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b0) begin
      errors++; $display("FAIL b_drop bvalid=%b required 0", axi.bvalid);
    end
  endtask

  // mode 0: rready always high, 1: toggling, 2: random
  task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input int mode);
    int idx, beat, guard, cyc;
    bit stalled;
    logic [127:0] pdata;
    logic [ID_W-1:0] pid;
    logic plast;
    idx = int'(addr[MEM_AW+3:4]);
    axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len); axi.arvalid = 1'b1;
    guard = 0;
    while (axi.arready !== 1'b1 && guard < 200) begin tick(); guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL ar_timeout arready=%b required 1", axi.arready);
    end
    tick();
    axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL r_early rvalid=%b required 0", axi.rvalid);
    end
    tick();
    checks++;
    if (axi.rvalid !== 1'b1) begin
      errors++; $display("FAIL r_latency rvalid=%b required 1", axi.rvalid);
    end
    beat = 0; guard = 0; stalled = 1'b0; cyc = 0;
    pdata = '0; pid = '0; plast = 1'b0;
    while (beat <= len && guard < 2000) begin
      case (mode)
        0:       axi.rready = 1'b1;
        1:       axi.rready = (cyc % 2 == 0);
        default: axi.rready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        checks++;
        if ({axi.rvalid, axi.rdata, axi.rid, axi.rlast} !== {1'b1, pdata, pid, plast}) begin
          errors++;
          $display("FAIL r_stall_hold got %b/%h/%h/%b required 1/%h/%h/%b", axi.rvalid, axi.rdata,
                   axi.rid, axi.rlast, pdata, pid, plast);
        end
      end
      if (axi.rvalid === 1'b1 && axi.rready) begin
        checks++;
        if (axi.rdata !== mdl[(idx + beat) % DEPTH]) begin
          errors++;
          $display("FAIL r_data beat %0d got %h required %h", beat, axi.rdata,
                   mdl[(idx + beat) % DEPTH]);
        end
        checks++;
        if ({axi.rid, axi.rresp, axi.rlast} !== {id, 2'b00, (beat == len)}) begin
          errors++;
          $display("FAIL r_ctrl beat %0d got id=%h resp=%b last=%b required id=%h resp=00 last=%b",
                   beat, axi.rid, axi.rresp, axi.rlast, id, (beat == len));
        end
        beat++;
      end
      stalled = (axi.rvalid === 1'b1) && !axi.rready;
      pdata = axi.rdata; pid = axi.rid; plast = axi.rlast;
      tick();
      cyc++; guard++;
    end
    axi.rready = 1'b0;
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL r_timeout beats=%0d required %0d", beat, len + 1);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != len + 1) begin
        errors++; $display("FAIL r_back_to_back cycles=%0d required %0d", cyc, len + 1);
      end
    end
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL r_drop rvalid=%b required 0", axi.rvalid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({init_done, axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast,
         axi.bresp, axi.rresp} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl done=%b awr=%b arr=%b wr=%b bv=%b rv=%b required all 0", init_done,
               axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid);
    end
    checks++;
    if ({axi.rdata, axi.rid, axi.bid} !== '0) begin
      errors++;
      $display("FAIL reset_data rdata=%h rid=%h bid=%h required 0", axi.rdata, axi.rid, axi.bid);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_CYCLES; k++) begin
      logic e;
      tick();
      e = (k >= INIT_CYCLES);
      checks++;
      if ({init_done, axi.awready, axi.arready} !== {3{e}}) begin
        errors++;
        $display("FAIL init_gate cycle %0d done/awr/arr=%b%b%b required %b", k, init_done,
                 axi.awready, axi.arready, e);
      end
    end
  endtask

  task automatic test_single();
    wbuf[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    axi_write(8'h3C, 32'h0000_0040, 0, 0, 16'hFFFF, 1'b0);
    axi_read(8'hA5, 32'h0000_0040, 0, 0);
  endtask

  task automatic test_burst_backpressure();
    logic [31:0] addr;
    logic [127:0] base;
    addr = {$urandom} & 32'hFFFF_FFF0;
    base = rnd128();
    for (int i = 0; i < 8; i++) wbuf[i] = base + 128'(i);
    axi_write(8'($urandom), addr, 7, 7, 16'hFFFF, 1'b1);
    axi_read(8'($urandom), addr, 7, 1);
  endtask

  task automatic test_strobe_wrap();
    for (int i = 0; i < 2; i++) wbuf[i] = rnd128();
    axi_write(8'h11, 32'h0000_3FF0, 1, 1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 2; i++) wbuf[i] = rnd128();
    axi_write(8'h22, 32'h5A00_3FF7, 1, 1, 16'h00FF, 1'b0);
    axi_read(8'h33, 32'h0000_3FF0, 1, 2);
  endtask

  task automatic test_wlast_errors();
    logic [31:0] addr;
    addr = 32'h0000_1000 | ({$urandom} & 32'h0000_0FF0);
    for (int i = 0; i < 4; i++) wbuf[i] = rnd128();
    axi_write(8'h40, addr, 3, 3, 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = rnd128();
    axi_write(8'h41, addr, 3, 1, 16'hFFFF, 1'b0);
    axi_read(8'h42, addr, 3, 0);
    for (int i = 0; i < 4; i++) wbuf[i] = rnd128();
    axi_write(8'h43, addr, 3, -1, 16'hFFFF, 1'b1);
    axi_read(8'h44, addr, 3, 2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [31:0] addr;
      int len;
      addr = {$urandom};
      len  = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) wbuf[i] = rnd128();
      axi_write(8'($urandom), addr, len, len, 16'hFFFF, 1'b1);
      for (int i = 0; i <= len; i++) wbuf[i] = rnd128();
      axi_write(8'($urandom), addr, len, len, 16'($urandom), 1'b1);
      axi_read(8'($urandom), addr, len, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [127:0] old_w, new_w;
    int idx;
    addr = {$urandom} & 32'hFFFF_FFF0;
    idx  = int'(addr[MEM_AW+3:4]);
    wbuf[0] = rnd128();
    axi_write(8'h51, addr, 0, 0, 16'hFFFF, 1'b0);
    old_w = mdl[idx];
    new_w = rnd128();
    axi.awid = 8'h52; axi.awaddr = addr; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    axi.arid = 8'h53; axi.araddr = addr; axi.arlen = 8'd0; axi.arvalid = 1'b1;
    checks++;
    if ({axi.awready, axi.arready} !== 2'b11) begin
      errors++; $display("FAIL same_cycle_ready got %b%b required 11", axi.awready, axi.arready);
    end
    tick();
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = new_w; axi.wstrb = 16'hFFFF; axi.wlast = 1'b1;
    axi.rready = 1'b1;
    checks++;
    if (axi.wready !== 1'b1) begin
      errors++; $display("FAIL collide_wready got %b required 1", axi.wready);
    end
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    checks++;
    if ({axi.rvalid, axi.rdata} !== {1'b1, old_w}) begin
      errors++;
      $display("FAIL collide_old_data rvalid=%b rdata=%h required 1/%h", axi.rvalid, axi.rdata, old_w);
    end
    checks++;
    if ({axi.bvalid, axi.bresp, axi.bid} !== {1'b1, 2'b00, 8'h52}) begin
      errors++;
      $display("FAIL collide_b got %b/%b/%h required 1/00/52", axi.bvalid, axi.bresp, axi.bid);
    end
    mdl[idx] = new_w;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    checks++;
    if ({axi.bvalid, axi.rvalid} !== 2'b00) begin
      errors++; $display("FAIL collide_drop bvalid/rvalid=%b%b required 00", axi.bvalid, axi.rvalid);
    end
    axi_read(8'h54, addr, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] waddr, raddr;
    int guard;
    waddr = 32'h0000_2000;
    raddr = 32'h0000_2100;
    for (int i = 0; i < 16; i++) wbuf[i] = rnd128();
    axi_write(8'h60, raddr, 15, 15, 16'hFFFF, 1'b0);
    wbuf[0] = rnd128();
    axi.awid = 8'h61; axi.awaddr = waddr; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    axi.arid = 8'h62; axi.araddr = raddr; axi.arlen = 8'd15; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = wbuf[0]; axi.wstrb = 16'hFFFF; axi.wlast = 1'b1;
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    mdl[int'(waddr[MEM_AW+3:4])] = wbuf[0];
    guard = 0;
    while (axi.rvalid !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++;
    if ({axi.rvalid, axi.bvalid} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_busy rvalid/bvalid=%b%b required 11", axi.rvalid, axi.bvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi.rvalid, axi.bvalid, init_done, axi.awready, axi.arready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async rv=%b bv=%b done=%b awr=%b arr=%b required all 0", axi.rvalid,
               axi.bvalid, init_done, axi.awready, axi.arready);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_CYCLES; k++) begin
      logic e;
      tick();
      e = (k >= INIT_CYCLES);
      checks++;
      if ({init_done, axi.awready, axi.arready, axi.rvalid, axi.bvalid} !== {{3{e}}, 2'b00}) begin
        errors++;
        $display("FAIL reinit cycle %0d done/awr/arr/rv/bv=%b%b%b%b%b required %b%b%b00", k,
                 init_done, axi.awready, axi.arready, axi.rvalid, axi.bvalid, e, e, e);
      end
    end
    axi_read(8'h63, waddr, 0, 0);
    axi_read(8'h64, raddr, 15, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_burst_backpressure();
    test_strobe_wrap();
    test_wlast_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded limit");
    $fatal(1);
  end

endmodule
